// File: rtl/fcpu_uart_fifo.sv
// fcpu_uart_fifo: FIFO-buffered UART between the fcpu byte channel and the board pins.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   uart_txd_in         serial line from the host (asynchronous, idles high)
//   uart_rxd_out        serial line to the host
//   i_data/i_valid/i_ready   TX byte stream into the TX FIFO
//   o_data/o_valid/o_ready   RX byte stream out of the show-ahead RX FIFO
//   tx_busy             TX FIFO non-empty or a frame on the line
//   rx_level            RX FIFO occupancy
//   parity_err, frame_err, overrun_err   sticky receive errors, cleared by err_clr
module fcpu_uart_fifo #(
  parameter int unsigned WTIME     = 16'h02c1,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned TX_DEPTH  = 16,
  parameter int unsigned RX_DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_txd_in,
  output logic                       uart_rxd_out,
  input  logic [DATA_BITS-1:0]       i_data,
  input  logic                       i_valid,
  output logic                       i_ready,
  output logic [DATA_BITS-1:0]       o_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic                       tx_busy,
  output logic [$clog2(RX_DEPTH):0]  rx_level,
  output logic                       parity_err,
  output logic                       frame_err,
  output logic                       overrun_err,
  input  logic                       err_clr
);

  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned TX_CW = TX_AW + 1;
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TW    = 16;
  localparam int unsigned BW    = 4;
  localparam logic [TW-1:0] T_LAST = TW'(WTIME - 1);
  localparam logic [TW-1:0] T_HALF = TW'(WTIME / 2);
  localparam logic          ODD    = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]     tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [TX_CW-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  // ---------------- TX FSM ----------------
  state_e               tx_state_q, tx_state_d;
  logic [TW-1:0]        tx_tick_q, tx_tick_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 txd_q, txd_d, tx_busy_q, tx_busy_d, i_ready_q, i_ready_d;
  logic                 tx_end;

  assign tx_push  = i_valid && i_ready_q;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rd_q];
  assign tx_end   = (tx_tick_q == T_LAST);

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= i_data;
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
      tx_busy_q  <= 1'b0;
      i_ready_q  <= 1'b1;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
      tx_busy_q  <= tx_busy_d;
      i_ready_q  <= i_ready_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  // TX next state; a pop (from IDLE or at the end of the last stop bit) loads the next frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = (tx_state_q == S_IDLE || tx_end) ? '0 : tx_tick_q + TW'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    unique case (tx_state_q)
      S_IDLE:  tx_pop = !tx_empty;
      S_START: if (tx_end) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
      end
      S_DATA: if (tx_end) begin
        tx_shift_d = tx_shift_q >> 1;
        tx_bit_d   = tx_bit_q + BW'(1);
        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
          tx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          tx_bit_d   = '0;
        end
      end
      S_PARITY: if (tx_end) tx_state_d = S_STOP;
      S_STOP: if (tx_end) begin
        if (tx_bit_q == BW'(STOP_BITS - 1)) begin
          tx_state_d = S_IDLE;
          tx_pop     = !tx_empty;
        end else begin
          tx_bit_d = tx_bit_q + BW'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_pop) begin
      tx_shift_d = tx_head;
      tx_par_d   = (^tx_head) ^ ODD;
      tx_state_d = S_START;
      tx_tick_d  = '0;
      tx_bit_d   = '0;
    end
    tx_wr_d  = tx_wr_q + TX_AW'(tx_push);
    tx_rd_d  = tx_rd_q + TX_AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + TX_CW'(tx_push) - TX_CW'(tx_pop);
  end

  // TX outputs, computed from next state so the line changes with the state register
  always_comb begin
    txd_d = 1'b1;
    unique case (tx_state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = tx_shift_d[0];
      S_PARITY: txd_d = tx_par_d;
      default:  txd_d = 1'b1;
    endcase
    tx_busy_d = (tx_state_d != S_IDLE) || (tx_cnt_d != '0);
    i_ready_d = (tx_cnt_d != TX_CW'(TX_DEPTH));
  end

  // ---------------- RX path ----------------
  logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  state_e               rx_state_q, rx_state_d;
  logic [TW-1:0]        rx_tick_q, rx_tick_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]     rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [RX_CW-1:0]     rx_cnt_q, rx_cnt_d;
  logic                 o_valid_q, o_valid_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
  logic                 rx_push, rx_pop, rx_full, rx_end, rx_par_bad;
  logic                 perr_set, ferr_set, oerr_set;

  assign rx_end     = (rx_tick_q == T_LAST);
  assign rx_full    = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_pop     = o_ready && o_valid_q;
  assign rx_par_bad = (PARITY != 0) && (((^rx_shift_q) ^ rx_par_q) != ODD);

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= rx_shift_q;
  end

  // RX state register, synchroniser and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      o_valid_q  <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      rx_s1_q    <= rx_s1_d;
      rx_s2_q    <= rx_s2_d;
      rx_prev_q  <= rx_prev_d;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      o_valid_q  <= o_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      oerr_q     <= oerr_d;
    end
  end

  // RX next state; start checked mid-bit, later samples one bit period apart
  always_comb begin
    rx_s1_d    = uart_txd_in;
    rx_s2_d    = rx_s1_q;
    rx_prev_d  = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q + TW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_push    = 1'b0;
    perr_set   = 1'b0;
    ferr_set   = 1'b0;
    oerr_set   = 1'b0;
    unique case (rx_state_q)
      S_IDLE: begin
        rx_tick_d = '0;
        if (rx_prev_q && !rx_s2_q) rx_state_d = S_START;
      end
      S_START: if (rx_tick_q == T_HALF) begin
        rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
        rx_tick_d  = '0;
        rx_bit_d   = '0;
      end
      S_DATA: if (rx_end) begin
        rx_tick_d  = '0;
        rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
        rx_bit_d   = rx_bit_q + BW'(1);
        if (rx_bit_q == BW'(DATA_BITS - 1))
          rx_state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (rx_end) begin
        rx_tick_d  = '0;
        rx_par_d   = rx_s2_q;
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_end) begin
        rx_tick_d  = '0;
        rx_state_d = S_IDLE;
        if (!rx_s2_q)        ferr_set = 1'b1;
        else if (rx_par_bad) perr_set = 1'b1;
        else if (rx_full)    oerr_set = 1'b1;
        else                 rx_push  = 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // RX FIFO bookkeeping and sticky flags (a set event beats a same-cycle clear)
  always_comb begin
    rx_wr_d   = rx_wr_q + RX_AW'(rx_push);
    rx_rd_d   = rx_rd_q + RX_AW'(rx_pop);
    rx_cnt_d  = rx_cnt_q + RX_CW'(rx_push) - RX_CW'(rx_pop);
    o_valid_d = (rx_cnt_d != '0);
    perr_d    = perr_set || (perr_q && !err_clr);
    ferr_d    = ferr_set || (ferr_q && !err_clr);
    oerr_d    = oerr_set || (oerr_q && !err_clr);
  end

  assign uart_rxd_out = txd_q;
  assign i_ready      = i_ready_q;
  assign tx_busy      = tx_busy_q;
  assign o_data       = rx_mem[rx_rd_q];
  assign o_valid      = o_valid_q;
  assign rx_level     = rx_cnt_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;
  assign overrun_err  = oerr_q;

endmodule

// File: tb/tb_fcpu_uart_fifo.sv
// tb_fcpu_uart_fifo: directed bench for fcpu_uart_fifo.
// u_dut: WTIME=16, 8N1, TX_DEPTH=16, RX_DEPTH=4. u_par: WTIME=16, 7E1, depth 4.
module tb_fcpu_uart_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, loop, rx_drv, rx_drv2;
  logic       d_txd, d_txd_in, d_i_valid, d_i_ready, d_o_valid, d_o_ready, d_busy;
  logic       d_perr, d_ferr, d_oerr, d_clr;
  logic [7:0] d_i_data, d_o_data;
  logic [2:0] d_level;
  logic       p_txd, p_i_valid, p_i_ready, p_o_valid, p_o_ready, p_busy;
  logic       p_perr, p_ferr, p_oerr, p_clr;
  logic [6:0] p_i_data, p_o_data;
  logic [2:0] p_level;

  int n_cmp = 0;
  int n_bad = 0;

  assign d_txd_in = loop ? d_txd : rx_drv;

  fcpu_uart_fifo #(.WTIME(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                   .TX_DEPTH(16), .RX_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .uart_txd_in(d_txd_in), .uart_rxd_out(d_txd),
    .i_data(d_i_data), .i_valid(d_i_valid), .i_ready(d_i_ready),
    .o_data(d_o_data), .o_valid(d_o_valid), .o_ready(d_o_ready),
    .tx_busy(d_busy), .rx_level(d_level), .parity_err(d_perr),
    .frame_err(d_ferr), .overrun_err(d_oerr), .err_clr(d_clr));

  fcpu_uart_fifo #(.WTIME(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1),
                   .TX_DEPTH(4), .RX_DEPTH(4)) u_par (
    .clk(clk), .rst(rst), .uart_txd_in(rx_drv2), .uart_rxd_out(p_txd),
    .i_data(p_i_data), .i_valid(p_i_valid), .i_ready(p_i_ready),
    .o_data(p_o_data), .o_valid(p_o_valid), .o_ready(p_o_ready),
    .tx_busy(p_busy), .rx_level(p_level), .parity_err(p_perr),
    .frame_err(p_ferr), .overrun_err(p_oerr), .err_clr(p_clr));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_drv = v;
    else            rx_drv2 = v;
  endtask

  // One frame into an RX input followed by one idle bit period
  task automatic send_frame(input int which, input logic [7:0] d, input int nbits,
                            input bit has_par, input logic par, input logic stop);
    set_line(which, 1'b0);
    tick(16);
    for (int i = 0; i < nbits; i++) begin
      set_line(which, d[i]);
      tick(16);
    end
    if (has_par) begin
      set_line(which, par);
      tick(16);
    end
    set_line(which, stop);
    tick(16);
    set_line(which, 1'b1);
    tick(16);
  endtask

  task automatic wait_low(input int which, input string tag);
    int n = 0;
    while (((which == 0) ? d_txd : p_txd) !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    chk(tag, (which == 0) ? d_txd : p_txd, 0);
  endtask

  task automatic wait_level(input int lvl, input int bound);
    int n = 0;
    while (d_level != 3'(lvl) && n < bound) begin
      tick(1);
      n++;
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, d_o_valid, 1);
    chk(tag, d_o_data, exp);
    d_o_ready = 1'b1;
    tick(1);
    d_o_ready = 1'b0;
  endtask

  initial begin
    logic [9:0]  fr;
    logic [15:0] smp;
    logic [9:0]  cap;
    logic [7:0]  bytes_in [5];
    logic        busy_last, prev;
    int          acc, n;

    rst = 1'b1; loop = 1'b0; rx_drv = 1'b1; rx_drv2 = 1'b1;
    d_i_data = '0; d_i_valid = 1'b0; d_o_ready = 1'b0; d_clr = 1'b0;
    p_i_data = '0; p_i_valid = 1'b0; p_o_ready = 1'b0; p_clr = 1'b0;
    busy_last = 1'b0;
    tick(3);
    rst = 1'b0;

    // Reset state
    chk("rst_txd", d_txd, 1);
    chk("rst_i_ready", d_i_ready, 1);
    chk("rst_o_valid", d_o_valid, 0);
    chk("rst_busy", d_busy, 0);
    chk("rst_level", d_level, 0);
    chk("rst_flags", {d_perr, d_ferr, d_oerr}, 0);

    // TX 0xA5, 8N1: every cycle of every bit period checked
    d_i_data = 8'hA5; d_i_valid = 1'b1;
    tick(1);
    d_i_valid = 1'b0;
    wait_low(0, "a5_start");
    fr = {1'b1, 8'hA5, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < 16; k++) begin
        smp[k] = d_txd;
        if (j == 9 && k == 15) busy_last = d_busy;
        tick(1);
      end
      chk($sformatf("a5_bit%0d", j), smp, {16{fr[j]}});
    end
    chk("a5_busy_159", busy_last, 1);
    chk("a5_busy_160", d_busy, 0);
    chk("a5_idle_line", d_txd, 1);

    // Loopback of three bytes
    loop = 1'b1;
    bytes_in[0] = 8'h00; bytes_in[1] = 8'hFF; bytes_in[2] = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      d_i_data = bytes_in[i]; d_i_valid = 1'b1;
      tick(1);
    end
    d_i_valid = 1'b0;
    wait_level(3, 1500);
    chk("lb_level", d_level, 3);
    tick(20);
    chk("lb_level_hold", d_level, 3);
    chk("lb_head_hold", d_o_data, 8'h00);
    chk("lb_flags", {d_perr, d_ferr, d_oerr}, 0);
    pop_chk("lb_pop0", 8'h00);
    pop_chk("lb_pop1", 8'hFF);
    pop_chk("lb_pop2", 8'h3C);
    chk("lb_empty", d_o_valid, 0);
    loop = 1'b0;

    // Overrun: five frames into a 4-deep RX FIFO
    bytes_in[0] = 8'hA1; bytes_in[1] = 8'hA2; bytes_in[2] = 8'hA3;
    bytes_in[3] = 8'hA4; bytes_in[4] = 8'hA5;
    for (int i = 0; i < 5; i++) send_frame(0, bytes_in[i], 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_level", d_level, 4);
    chk("ovr_flag", d_oerr, 1);
    chk("ovr_other_flags", {d_perr, d_ferr}, 0);
    for (int i = 0; i < 4; i++) pop_chk($sformatf("ovr_pop%0d", i), bytes_in[i]);
    chk("ovr_empty", d_o_valid, 0);
    d_clr = 1'b1;
    tick(1);
    d_clr = 1'b0;
    chk("ovr_clr", d_oerr, 0);

    // 8-cycle low glitch is a false start
    rx_drv = 1'b0;
    tick(8);
    rx_drv = 1'b1;
    tick(40);
    chk("glitch_level", d_level, 0);
    chk("glitch_flags", {d_perr, d_ferr, d_oerr}, 0);

    // Stop bit low: frame error, byte dropped; flag stays sticky across a good frame
    send_frame(0, 8'h55, 8, 1'b0, 1'b0, 1'b0);
    chk("ferr_flag", d_ferr, 1);
    chk("ferr_level", d_level, 0);
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b1);
    chk("good_level", d_level, 1);
    chk("good_data", d_o_data, 8'h3C);
    chk("ferr_sticky", d_ferr, 1);

    // 7E1: 0x07 has three ones, so the even-parity bit is 1
    p_i_data = 7'h07; p_i_valid = 1'b1;
    tick(1);
    p_i_valid = 1'b0;
    wait_low(1, "par_start");
    for (int j = 0; j < 10; j++) begin
      tick(8);
      cap[j] = p_txd;
      tick(8);
    end
    chk("par_frame", cap, 10'b11_0000111_0);
    send_frame(1, 8'h07, 7, 1'b1, 1'b0, 1'b1);
    chk("par_err", p_perr, 1);
    chk("par_level", p_level, 0);
    p_clr = 1'b1;
    tick(1);
    p_clr = 1'b0;
    chk("par_clr", p_perr, 0);
    send_frame(1, 8'h07, 7, 1'b1, 1'b1, 1'b1);
    chk("par_ok_level", p_level, 1);
    chk("par_ok_data", p_o_data, 7'h07);
    chk("par_ok_flag", p_perr, 0);

    // TX fill with i_valid held: FIFO plus shift register
    acc = 0;
    d_i_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (d_i_ready) acc++;
      d_i_data = 8'(acc);
      tick(1);
    end
    chk("fill_count", acc, 17);
    chk("fill_ready", d_i_ready, 0);
    n = 0;
    prev = d_txd;
    while (!d_i_ready && n < 400) begin
      prev = d_txd;
      tick(1);
      n++;
    end
    chk("next_start_line", d_txd, 0);
    chk("prev_stop_line", prev, 1);
    tick(1);
    d_i_valid = 1'b0;
    chk("refill_ready", d_i_ready, 0);

    // Reset mid TX DATA and mid RX frame
    rx_drv = 1'b0;
    tick(40);
    rst = 1'b1;
    rx_drv = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mrst_txd", d_txd, 1);
    chk("mrst_i_ready", d_i_ready, 1);
    chk("mrst_o_valid", d_o_valid, 0);
    chk("mrst_busy", d_busy, 0);
    chk("mrst_level", d_level, 0);
    chk("mrst_flags", {d_perr, d_ferr, d_oerr}, 0);
    tick(200);
    chk("mrst_level_late", d_level, 0);
    chk("mrst_txd_late", d_txd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fcpu_uart_fifo.md
Name: fcpu_uart_fifo

Overview:
Parametrised successor to the fixed-format serial interface between fcpu's byte IO channel and the board UART pins. It adds TX and RX FIFOs, selectable data width, parity and stop bits, a 2-flop RX synchroniser, false-start rejection, and sticky error flags. It sits in the top level, on the same clock as the CPU (ui_clk), in place of the existing serial interface.

Parameters:
WTIME, 16'h02c1, clock cycles per UART bit; must be >= 4.
DATA_BITS, 8, payload bits per frame, 5..8; sent LSB first.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, 1 or 2.
TX_DEPTH, 16, TX FIFO entries; power of 2, >= 2.
RX_DEPTH, 16, RX FIFO entries; power of 2, >= 2.

Ports:
clk  in  1  single clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
uart_txd_in  in  1  serial line from the host (RX direction); idles high; asynchronous.
uart_rxd_out  out  1  serial line to the host (TX direction).
i_data  in  DATA_BITS  byte to transmit.
i_valid  in  1  i_data valid.
i_ready  out  1  TX FIFO not full.
o_data  out  DATA_BITS  head of RX FIFO.
o_valid  out  1  RX FIFO not empty.
o_ready  in  1  consumer accepts o_data.
tx_busy  out  1  TX FIFO non-empty or a frame is in flight.
rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy.
parity_err  out  1  sticky parity error.
frame_err  out  1  sticky stop-bit error.
overrun_err  out  1  sticky: a received byte was dropped because the RX FIFO was full.
err_clr  in  1  one-cycle pulse; clears all three error flags.

Behaviour:
- Reset state: uart_rxd_out=1, i_ready=1, o_valid=0, tx_busy=0, rx_level=0, all error flags 0. Both FIFOs are emptied. Both FSMs go to IDLE. Bit counters are zeroed. A reset mid-frame aborts the frame; the line returns high on the next cycle.
- Handshakes: a transfer occurs when valid and ready are both 1 on a rising edge. The FIFOs are show-ahead: o_data is stable while o_valid=1 and o_ready=0. A push and a pop in the same cycle leave the level unchanged. Push-while-full and pop-while-empty are ignored.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register and go to START.
  - Each state holds its line value for exactly WTIME cycles, counted 0..WTIME-1.
  - START drives 0. DATA shifts out DATA_BITS bits, LSB first. PARITY is skipped when PARITY=0. STOP drives 1 for STOP_BITS bit periods.
  - Back-to-back frames: after STOP, pop immediately if data is waiting; no extra idle gap.
  - Total capacity is TX_DEPTH bytes in the FIFO plus 1 in the shift register.
- RX path: uart_txd_in passes through 2 flops before use, giving 2 cycles of latency.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: a synchronised 1->0 transition enters START.
  - START samples the line at count WTIME/2 (integer division). If the sample is 1 it is a false start: return to IDLE with no flags set.
  - Later samples are taken every WTIME cycles after the start sample: DATA_BITS data bits, then parity if enabled, then one stop bit. Only the first stop bit is checked.
- Stop-bit sample, evaluated in this order:
  - stop=0: set frame_err, discard the byte.
  - Parity mismatch: set parity_err, discard the byte.
  - RX FIFO full: set overrun_err, discard the byte.
  - Otherwise push the byte.
  - The FSM returns to IDLE on the cycle after the stop sample, so the next start edge can be detected during the rest of the stop bit.
- Parity: the odd-parity bit makes the count of 1s in data+parity odd; the even-parity bit makes it even.
- Error flags: each set-event holds its flag at 1 until err_clr. If err_clr and a set-event occur in the same cycle, set wins.
- tx_busy drops on the cycle after the final stop-bit period ends with the TX FIFO empty.

Test Plan:
- WTIME=16, 8N1; push 0xA5 -> uart_rxd_out goes low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high; tx_busy deasserts 160 cycles after the first low.
- Loop uart_rxd_out back to uart_txd_in; send 0x00, 0xFF, 0x3C -> the same three bytes appear in order on o_data; rx_level reaches 3 with o_ready=0; no error flags set.
- PARITY=2, DATA_BITS=7; push 0x07 -> the parity bit is 1; RX drives a frame for 0x07 with parity 0 -> parity_err=1, rx_level stays 0; an err_clr pulse -> parity_err=0.
- RX_DEPTH=4, o_ready=0; inject 5 valid frames -> rx_level=4 and overrun_err=1; the popped data are frames 1-4. An 8-cycle low glitch -> no byte and no flag. A frame with stop=0 -> frame_err=1.
- TX with i_valid held high and the line running -> exactly TX_DEPTH+1=17 bytes are accepted before i_ready=0. A new byte is accepted only after the next frame's START begins.
- Assert rst for 1 cycle during the DATA state of a TX frame and during an RX frame -> next cycle uart_rxd_out=1, i_ready=1, o_valid=0, flags 0, and no partial byte appears in the RX FIFO.
